phase_sequencer: RTL

//  Multi-cycle RV32I phase sequencer in the Control_Unit, clocked by ClockGen's CLK.

---
 rtl/phase_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Multi-cycle RV32I phase sequencer: steps each instruction through
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK according to its opcode class,
// drives per-phase enables, counts retired instructions and halts on
// SYSTEM opcodes, illegal opcodes, memory timeouts or an external halt request.
module phase_sequencer #(
    parameter int RESET_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } stateT;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_BRANCH = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_ALU    = 3'd4
    } classT;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int BW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(MEM_TIMEOUT - 1);

    stateT            stateReg, stateNext;
    classT            opClassReg, opClassNext, decodedClass;
    logic [BW-1:0]    bootCntReg, bootCntNext;
    logic [TW-1:0]    toCntReg, toCntNext;
    logic             faultReg, faultNext;
    logic [CNT_W-1:0] instretReg;
    logic             toBoundary;

    // Opcode classification; anything not listed is illegal (SYSTEM handled separately).
    always_comb begin
        decodedClass = C_NONE;
        case (opcode)
            7'b1100011: decodedClass = C_BRANCH;
            7'b0000011: decodedClass = C_LOAD;
            7'b0100011: decodedClass = C_STORE;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: decodedClass = C_ALU;
            default:    decodedClass = C_NONE;
        endcase
    end

    // State, counters and sticky fault; reset aborts any instruction in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateReg   <= S_BOOT;
            opClassReg <= C_NONE;
            bootCntReg <= '0;
            toCntReg   <= '0;
            faultReg   <= 1'b0;
            instretReg <= '0;
        end else begin
            stateReg   <= stateNext;
            opClassReg <= opClassNext;
            bootCntReg <= bootCntNext;
            toCntReg   <= toCntNext;
            faultReg   <= faultNext;
            if (pc_we) begin
                instretReg <= instretReg + 1'b1;
            end
        end
    end

    // Next-state and Moore-plus-ready outputs; retirement coincides with pc_we.
    always_comb begin
        stateNext   = stateReg;
        opClassNext = opClassReg;
        bootCntNext = bootCntReg;
        toCntNext   = toCntReg;
        faultNext   = faultReg;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        halted      = 1'b0;
        toBoundary  = 1'b0;
        case (stateReg)
            S_BOOT: begin
                if (bootCntReg == BOOT_LAST) begin
                    toBoundary = 1'b1;
                end else begin
                    bootCntNext = bootCntReg + 1'b1;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    toCntNext = '0;
                    stateNext = S_DECODE;
                end else if (toCntReg == TO_LAST) begin
                    // Timeout cycle: request withdrawn, nothing enabled.
                    mem_req   = 1'b0;
                    faultNext = 1'b1;
                    stateNext = S_HALT;
                end else begin
                    toCntNext = toCntReg + 1'b1;
                end
            end
            S_DECODE: begin
                opClassNext = decodedClass;
                if (opcode == OP_SYSTEM) begin
                    stateNext = S_HALT;
                end else if (decodedClass == C_NONE) begin
                    faultNext = 1'b1;
                    stateNext = S_HALT;
                end else begin
                    stateNext = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opClassReg)
                    C_BRANCH: begin
                        pc_we      = 1'b1;
                        toBoundary = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        toCntNext = '0;
                        stateNext = S_MEM;
                    end
                    C_ALU:   stateNext = S_WB;
                    default: begin
                        faultNext = 1'b1;
                        stateNext = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opClassReg == C_STORE);
                if (mem_ready) begin
                    toCntNext = '0;
                    if (opClassReg == C_STORE) begin
                        pc_we      = 1'b1;
                        toBoundary = 1'b1;
                    end else begin
                        stateNext = S_WB;
                    end
                end else if (toCntReg == TO_LAST) begin
                    mem_req   = 1'b0;
                    mem_we    = 1'b0;
                    faultNext = 1'b1;
                    stateNext = S_HALT;
                end else begin
                    toCntNext = toCntReg + 1'b1;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                toBoundary = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                stateNext = S_HALT;
            end
        endcase
        // Instruction boundary: the only place an external halt is honoured.
        if (toBoundary) begin
            toCntNext = '0;
            stateNext = halt_req ? S_HALT : S_FETCH;
        end
    end

    assign state   = stateReg;
    assign fault   = faultReg;
    assign instret = instretReg;

endmodule
